// File: rtl/mem_pkg.sv
// Shared data-memory port types and memory-latency constants.
// Used by the dmem arbiter and anything else speaking the dmem protocol.
package mem_pkg;

    // Read latencies matching the MEMORY_TYPE build options.
    localparam int RD_LAT_SYNTH = 0;
    localparam int RD_LAT_BSRAM = 1;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    typedef struct packed {
        logic [MEM_DATA_W/8-1:0] wstrb;
        logic [MEM_ADDR_W-1:0]   addr;
        logic [MEM_DATA_W-1:0]   wdata;
        logic                    req;
    } mem_req_t;

    typedef struct packed {
        logic                  gnt;
        logic                  rvalid;
        logic [MEM_DATA_W-1:0] rdata;
    } mem_rsp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant logic: round-robin or fixed priority (req0 wins).
// Ports: clk, rst (sync, active high), req0/req1 in, gnt0/gnt1 out.
module rr_arb2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    // 1 means requester 1 owned the port last, so requester 0
    // takes the next conflict.
    logic last_owner;
    logic m0_wins;

    always_comb begin
        m0_wins = (FIXED_PRIO != 0) || last_owner;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        if (!rst) begin
            if (req0 && (!req1 || m0_wins)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= 1'b1;
        end else if (gnt0) begin
            last_owner <= 1'b0;
        end else if (gnt1) begin
            last_owner <= 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one dmem port between the core LSU (m0) and a debug/loader (m1).
// Ports: m0_*/m1_* requester sides, mem_* to dmem, conflict status out.
module dmem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                mem_ce,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                conflict
);

    logic rd0;
    logic rd1;

    rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req0(m0_req),
        .req1(m1_req),
        .gnt0(m0_gnt),
        .gnt1(m1_gnt)
    );

    assign conflict = m0_req & m1_req;
    assign mem_ce   = m0_gnt | m1_gnt;

    // Idle port parks on m0's address/data; zero strobes keep it harmless.
    always_comb begin
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wstrb = '0;
        if (m1_gnt) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_wstrb = m1_wstrb;
        end else if (m0_gnt) begin
            mem_wstrb = m0_wstrb;
        end
    end

    assign rd0 = m0_gnt & ~(|m0_wstrb);
    assign rd1 = m1_gnt & ~(|m1_wstrb);

    // Both sides see the memory output; rvalid says whose it is.
    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;

    if (RD_LAT == RD_LAT_SYNTH) begin : g_async
        assign m0_rvalid = rd0;
        assign m1_rvalid = rd1;
    end else begin : g_sync
        logic pend_v;
        logic pend_own;

        always_ff @(posedge clk) begin
            if (rst) begin
                pend_v   <= 1'b0;
                pend_own <= 1'b0;
            end else begin
                pend_v   <= rd0 | rd1;
                pend_own <= rd1;
            end
        end

        // Gating with rst drops a read that was in flight when reset hit.
        assign m0_rvalid = pend_v & ~pend_own & ~rst;
        assign m1_rvalid = pend_v & pend_own & ~rst;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin BSRAM instance with a
// memory model, plus a fixed-priority async instance.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;

    logic        m0_req, m1_req;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_ce, conflict;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        f_m0_req, f_m1_req;
    logic [3:0]  f_m0_wstrb, f_m1_wstrb;
    logic [31:0] f_m0_addr, f_m1_addr, f_m0_wdata, f_m1_wdata;
    logic        f_m0_gnt, f_m1_gnt, f_m0_rvalid, f_m1_rvalid;
    logic [31:0] f_m0_rdata, f_m1_rdata;
    logic        f_mem_ce, f_conflict;
    logic [3:0]  f_mem_wstrb;
    logic [31:0] f_mem_addr, f_mem_wdata, f_mem_rdata;

    logic [31:0] mem [64];

    int vec;
    int errs;

    dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .RD_LAT(1), .FIXED_PRIO(0)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .mem_ce(mem_ce), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conflict(conflict)
    );

    dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .RD_LAT(0), .FIXED_PRIO(1)
    ) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(f_m0_req), .m0_wstrb(f_m0_wstrb), .m0_addr(f_m0_addr),
        .m0_wdata(f_m0_wdata), .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid),
        .m0_rdata(f_m0_rdata),
        .m1_req(f_m1_req), .m1_wstrb(f_m1_wstrb), .m1_addr(f_m1_addr),
        .m1_wdata(f_m1_wdata), .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid),
        .m1_rdata(f_m1_rdata),
        .mem_ce(f_mem_ce), .mem_wstrb(f_mem_wstrb), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata),
        .conflict(f_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BSRAM model: read-before-write, one cycle latency.
    always @(posedge clk) begin
        if (mem_ce) begin
            mem_rdata <= mem[mem_addr[7:2]];
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        m0_req = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'h0;
        m1_req = 1'b1; m1_addr = 32'h14; m1_wstrb = 4'h0;
        @(negedge clk);
        vec++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
            errs++;
            $display("FAIL rst_gnt: got %b%b want 00", m0_gnt, m1_gnt);
        end
        vec++;
        if (mem_ce !== 1'b0 || mem_wstrb !== 4'h0) begin
            errs++;
            $display("FAIL rst_mem: ce %b wstrb %h want 0 0", mem_ce, mem_wstrb);
        end
        cyc();
        rst = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        vec++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            errs++;
            $display("FAIL rst_rvalid: got %b%b want 00", m0_rvalid, m1_rvalid);
        end
        cyc();
    endtask

    task automatic test_conflict();
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h20; m0_wstrb = 4'h0;
        m1_req = 1'b1; m1_addr = 32'h24; m1_wstrb = 4'hF;
        m1_wdata = 32'h12345678;
        @(negedge clk);
        vec++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || conflict !== 1'b1) begin
            errs++;
            $display("FAIL conf_c0: gnt %b%b conflict %b want 10 1",
                     m0_gnt, m1_gnt, conflict);
        end
        cyc();
        m0_req = 1'b0;
        @(negedge clk);
        vec++;
        if (m1_gnt !== 1'b1 || mem_wstrb !== 4'hF || mem_addr !== 32'h24) begin
            errs++;
            $display("FAIL conf_c1_wr: gnt %b wstrb %h addr %h want 1 f 24",
                     m1_gnt, mem_wstrb, mem_addr);
        end
        vec++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hCAFEF00D || m1_rvalid !== 1'b0) begin
            errs++;
            $display("FAIL conf_c1_rd: rv %b data %h m1rv %b want 1 cafef00d 0",
                     m0_rvalid, m0_rdata, m1_rvalid);
        end
        cyc();
        m1_req = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h24;
        @(negedge clk);
        cyc();
        m0_req = 1'b0;
        @(negedge clk);
        vec++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h12345678) begin
            errs++;
            $display("FAIL conf_readback: rv %b data %h want 1 12345678",
                     m0_rvalid, m0_rdata);
        end
        cyc();
    endtask

    task automatic test_single_read();
        m0_req = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'h0;
        @(negedge clk);
        vec++;
        if (m0_gnt !== 1'b1 || mem_ce !== 1'b1 || mem_addr !== 32'h10
            || m1_rvalid !== 1'b0) begin
            errs++;
            $display("FAIL single_c0: gnt %b ce %b addr %h m1rv %b want 1 1 10 0",
                     m0_gnt, mem_ce, mem_addr, m1_rvalid);
        end
        cyc();
        m0_req = 1'b0;
        @(negedge clk);
        vec++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL single_c1: rv %b data %h want 1 deadbeef",
                     m0_rvalid, m0_rdata);
        end
        vec++;
        if (m1_rvalid !== 1'b0 || m1_rdata !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL single_m1: rv %b data %h want 0 deadbeef",
                     m1_rvalid, m1_rdata);
        end
        cyc();
    endtask

    task automatic test_rr_contention();
        int n0;
        int n1;
        logic exp0;
        n0 = 0;
        n1 = 0;
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h40; m0_wstrb = 4'h0;
        m1_req = 1'b1; m1_addr = 32'h44; m1_wstrb = 4'h0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp0 = (k % 2 == 0);
            vec++;
            if (m0_gnt !== exp0 || m1_gnt !== !exp0) begin
                errs++;
                $display("FAIL rr_gnt[%0d]: got %b%b want %b%b",
                         k, m0_gnt, m1_gnt, exp0, !exp0);
            end
            if (k > 0) begin
                vec++;
                if (exp0) begin
                    if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0
                        || m1_rdata !== 32'hB1B1B1B1) begin
                        errs++;
                        $display("FAIL rr_rv[%0d]: rv %b%b data %h want 01 b1b1b1b1",
                                 k, m0_rvalid, m1_rvalid, m1_rdata);
                    end
                end else begin
                    if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0
                        || m0_rdata !== 32'hA0A0A0A0) begin
                        errs++;
                        $display("FAIL rr_rv[%0d]: rv %b%b data %h want 10 a0a0a0a0",
                                 k, m0_rvalid, m1_rvalid, m0_rdata);
                    end
                end
            end
            if (m0_gnt === 1'b1) n0++;
            if (m1_gnt === 1'b1) n1++;
            cyc();
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        vec++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hB1B1B1B1) begin
            errs++;
            $display("FAIL rr_last_rv: rv %b data %h want 1 b1b1b1b1",
                     m1_rvalid, m1_rdata);
        end
        vec++;
        if (n0 != 4 || n1 != 4) begin
            errs++;
            $display("FAIL rr_counts: got %0d/%0d want 4/4", n0, n1);
        end
        cyc();
    endtask

    task automatic test_fixed_prio();
        f_m0_req = 1'b1; f_m0_addr = 32'h50; f_m0_wstrb = 4'h0;
        f_m1_req = 1'b1; f_m1_addr = 32'h54; f_m1_wstrb = 4'h0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vec++;
            if (f_m0_gnt !== 1'b1 || f_m1_gnt !== 1'b0) begin
                errs++;
                $display("FAIL fp_gnt[%0d]: got %b%b want 10", k, f_m0_gnt, f_m1_gnt);
            end
            if (k == 0) begin
                vec++;
                if (f_m0_rvalid !== 1'b1 || f_m0_rdata !== 32'h5A5A0001
                    || f_mem_addr !== 32'h50) begin
                    errs++;
                    $display("FAIL fp_async_rd: rv %b data %h addr %h want 1 5a5a0001 50",
                             f_m0_rvalid, f_m0_rdata, f_mem_addr);
                end
            end
            cyc();
        end
        f_m0_req = 1'b0;
        @(negedge clk);
        vec++;
        if (f_m1_gnt !== 1'b1 || f_m1_rvalid !== 1'b1 || f_mem_addr !== 32'h54) begin
            errs++;
            $display("FAIL fp_m1_after: gnt %b rv %b addr %h want 1 1 54",
                     f_m1_gnt, f_m1_rvalid, f_mem_addr);
        end
        cyc();
        f_m1_req = 1'b0;
    endtask

    task automatic test_byte_write();
        m1_req = 1'b1; m1_addr = 32'h30; m1_wstrb = 4'b0010;
        m1_wdata = 32'h0000AB00;
        @(negedge clk);
        vec++;
        if (m1_gnt !== 1'b1 || mem_wstrb !== 4'b0010 || mem_wdata !== 32'h0000AB00) begin
            errs++;
            $display("FAIL bw_write: gnt %b wstrb %h wdata %h want 1 2 0000ab00",
                     m1_gnt, mem_wstrb, mem_wdata);
        end
        cyc();
        vec++;
        if (m1_rvalid !== 1'b0) begin
            errs++;
            $display("FAIL bw_no_rv: got %b want 0", m1_rvalid);
        end
        m1_wstrb = 4'h0;
        @(negedge clk);
        cyc();
        m1_req = 1'b0;
        @(negedge clk);
        vec++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h1122AB44 || m0_rvalid !== 1'b0) begin
            errs++;
            $display("FAIL bw_readback: rv %b data %h m0rv %b want 1 1122ab44 0",
                     m1_rvalid, m1_rdata, m0_rvalid);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        m0_req = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'h0;
        @(negedge clk);
        cyc();
        m0_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        vec++;
        if (m0_rvalid !== 1'b0) begin
            errs++;
            $display("FAIL mid_discard: rv %b want 0", m0_rvalid);
        end
        cyc();
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if (m0_rvalid !== 1'b0) begin
            errs++;
            $display("FAIL mid_after: rv %b want 0", m0_rvalid);
        end
        cyc();
        m0_req = 1'b1; m0_addr = 32'h40;
        m1_req = 1'b1; m1_addr = 32'h44; m1_wstrb = 4'h0;
        @(negedge clk);
        vec++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            errs++;
            $display("FAIL mid_first_conf: gnt %b%b want 10", m0_gnt, m1_gnt);
        end
        cyc();
        m0_req = 1'b0;
        m1_req = 1'b0;
        cyc();
    endtask

    initial begin
        vec = 0;
        errs = 0;
        rst = 1'b1;
        m0_req = 1'b0; m0_wstrb = 4'h0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_wstrb = 4'h0; m1_addr = '0; m1_wdata = '0;
        f_m0_req = 1'b0; f_m0_wstrb = 4'h0; f_m0_addr = '0; f_m0_wdata = '0;
        f_m1_req = 1'b0; f_m1_wstrb = 4'h0; f_m1_addr = '0; f_m1_wdata = '0;
        f_mem_rdata = 32'h5A5A0001;
        mem_rdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]  = 32'hDEADBEEF;
        mem[8]  = 32'hCAFEF00D;
        mem[12] = 32'h11223344;
        mem[16] = 32'hA0A0A0A0;
        mem[17] = 32'hB1B1B1B1;
        #1;
        test_reset();
        test_conflict();
        test_single_read();
        test_rr_contention();
        test_fixed_prio();
        test_byte_write();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single data-memory port (dmem) between the core load/store unit (requester 0) and a debug/loader requester (requester 1), e.g. a program loader or memory inspector.
- Sits between `core` / the debug port and `dmem` in `top`.
- Grants at most one access per cycle and routes read data back to the correct requester.
- Read data is pipelined to match either async (SYNTH_MEM) or synchronous (BSRAM_MEM) memory.

Parameters:
- ADDR_W, 32, address width of requesters and memory port.
- DATA_W, 32, data width; byte-strobe width is DATA_W/8.
- RD_LAT, 1, memory read latency in cycles: 0 = SYNTH_MEM (async), 1 = BSRAM_MEM.
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins conflicts.

Ports:
- clk  in  1  clock, shared with core and dmem.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  requester 0 access request; held until m0_gnt.
- m0_wstrb  in  DATA_W/8  byte write strobes; all zero means read.
- m0_addr  in  ADDR_W  byte address.
- m0_wdata  in  DATA_W  write data.
- m0_gnt  out  1  access accepted this cycle.
- m0_rvalid  out  1  read data valid.
- m0_rdata  out  DATA_W  read data.
- m1_req, m1_wstrb, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_* for requester 1.
- mem_ce  out  1  memory access enable, equal to m0_gnt|m1_gnt.
- mem_wstrb  out  DATA_W/8  to dmem wstrb.
- mem_addr  out  ADDR_W  to dmem a.
- mem_wdata  out  DATA_W  to dmem wd.
- mem_rdata  in  DATA_W  from dmem rd.
- conflict  out  1  both requests active this cycle (debug/stat).

Behaviour:
- Arbitration (combinational, same cycle):
  - Only one request: granted immediately.
  - Both requests: round-robin grants the requester not granted last; FIXED_PRIO=1 grants m0.
  - gnt is a combinational pulse in the accept cycle, asserted for exactly one requester at most.
  - mem_* carries the winner's signals.
- Idle outputs: with no grant, mem_wstrb=0, mem_ce=0, mem_addr/mem_wdata = m0 values (don't-care, no write).
- Requester rule: hold req/addr/wstrb/wdata stable until gnt. Dropping req before gnt is legal and cancels the request.
- Round-robin state: last_owner register, updated on every grant. Reset value 1, so m0 wins the first conflict.
- Writes:
  - Complete in the grant cycle; no rvalid is generated.
  - Memory sees the write on the same clock edge that samples gnt.
- Reads, RD_LAT=0:
  - rvalid of the owner = its gnt, same cycle.
  - rdata = mem_rdata, combinational.
- Reads, RD_LAT=1:
  - Registered pending-read tag (valid bit + owner bit) is set in the grant cycle.
  - Next cycle: rvalid asserted for the tagged owner only; rdata = mem_rdata (BSRAM output).
  - Back-to-back reads are fully pipelined, one per cycle, with no bubbles; this also holds when the owner alternates.
- Non-owner rdata: the non-owner's rdata is still driven with mem_rdata (no muxing to 0), but its rvalid stays 0.
- Read followed by write in the next cycle: legal. The read's rvalid still occurs; the write is issued in parallel.
- Reset:
  - All gnt, rvalid, mem_ce and mem_wstrb deassert.
  - Pending-read tag clears.
  - last_owner := 1.
  - A read granted in the cycle rst is asserted returns no rvalid.
  - Reset mid-stream discards all in-flight reads.
- Width rules:
  - Addresses are passed through unchanged; dmem does its own word indexing.
  - No address decoding or range checking.
- Throughput: 1 access per cycle total. Under continuous contention in round-robin mode each requester gets exactly every other cycle. No starvation in either mode, except m1 under FIXED_PRIO=1 (documented).

Decomposition:
- Shared package (mem_pkg):
  - typedef mem_req_t {wstrb, addr, wdata, req}.
  - typedef mem_rsp_t {gnt, rvalid, rdata}.
  - localparams RD_LAT_SYNTH=0, RD_LAT_BSRAM=1, matching the MEMORY_TYPE defines.
- Sub-module rr_arb2 (2-input round-robin/fixed-priority grant logic plus last_owner register). Datapath muxing and the read-tag pipeline stay in the top.

Test Plan:
- RD_LAT=1, m0 reads addr 0x10 (mem holds 0xDEADBEEF), m1 idle -> m0_gnt in cycle 0; m0_rvalid=1 and m0_rdata=0xDEADBEEF in cycle 1; m1_rvalid=0 throughout.
- Both request in cycle 0 after reset, m0 reads 0x20 and m1 writes 0x12345678 to 0x24 with wstrb=4'hF:
  - cycle 0: m0_gnt, conflict=1.
  - cycle 1: m1_gnt, mem_wstrb=4'hF, m0_rvalid.
  - later read of 0x24 returns 0x12345678.
- Continuous contention for 8 cycles, both reading, round-robin -> grants alternate m0,m1,m0,…; each rvalid arrives one cycle after its gnt to the correct owner; 4 grants each.
- FIXED_PRIO=1, same 8-cycle contention -> m0_gnt every cycle, m1_gnt never; m1 granted the cycle after m0_req drops.
- m1 byte write wstrb=4'b0010, wdata=0x0000AB00 to 0x30 (prior 0x11223344) -> readback 0x1122AB44.
- rst asserted in the cycle m0's read is granted -> no m0_rvalid next cycle. After reset release, the first conflict grants m0.
